div_issue_arbiter: RTL and testbench
====================================

Name: div_issue_arbiter

Overview:
Controller that shares one iterative divider among NUM_REQ divide reservation-station ports.
- Round-robin arbitration picks one ready requester and captures its operands, command and ROB tag.
- Sequences the divider through a start pulse, waits for its done, and bypasses the divider for divide-by-zero.
- Holds the result on a valid/canGo writeback handshake toward the execution decision unit.
- Sits between the divide reservation stations and the divider, in the issue/execute stage.

Parameters:
NUM_REQ, 4, number of requesting reservation-station ports (>=2)
ROBsize, 32, ROB entries
ROBsizeLog, $clog2(ROBsize+1), tag width

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-low reset
req_i  in  NUM_REQ  requester k has a ready divide op
val1_i  in  NUM_REQ*64  dividends, requester k at [64k+63:64k]
val2_i  in  NUM_REQ*64  divisors, same packing
commands_i  in  NUM_REQ*10  command words, requester k at [10k+9:10k]
tag_i  in  NUM_REQ*ROBsizeLog  ROB tags, same packing
grant_o  out  NUM_REQ  one-hot grant; requester k deasserts req_i[k] next cycle
flush_i  in  1  pipeline flush; abandons any in-flight op
divStart_o  out  1  one-cycle start pulse to the divider
divDividend_o  out  64  registered dividend
divDivisor_o  out  64  registered divisor
divAbort_o  out  1  one-cycle reset pulse to the divider
divDone_i  in  1  divider result valid
divQuotient_i  in  64  divider result
valid_o  out  1  writeback result valid
executeVal_o  out  64  result
executeCommands_o  out  10  command of the op in flight
executeTag_o  out  ROBsizeLog  tag of the op in flight
canGo_i  in  1  writeback accepted when valid_o & canGo_i
busy_o  out  1  state != IDLE

Behaviour:
- Reset (reset_i=0, asynchronous):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - All outputs are 0, including grant_o, divStart_o, divAbort_o, valid_o, every data/tag/command register, and busy_o.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - grant_o is combinational and nonzero only when req_i != 0 and flush_i=0.
  - Winner is the first set req bit searching upward from the pointer, with wrap-around.
  - On the grant edge:
    - Capture the winner's val1/val2/commands/tag.
    - Pointer <= (winner+1) mod NUM_REQ.
    - If the winner's val2 == 0, set executeVal_o <= 64'hFFFF_FFFF_FFFF_FFFF and go to DONE, with no divider use.
    - Otherwise go to LAUNCH.
- LAUNCH:
  - divStart_o=1 for exactly this cycle, with divDividend_o/divDivisor_o stable.
  - Next state is WAIT.
- WAIT:
  - On divDone_i=1: executeVal_o <= divQuotient_i, then go to DONE.
  - divDone_i in any other state is ignored.
- DONE:
  - valid_o=1; executeVal_o/Commands/Tag are held stable while canGo_i=0.
  - On canGo_i=1 go to IDLE.
  - No grant in the same cycle, so there is one bubble between ops.
- Latency, from grant edge at cycle 0:
  - divStart_o is high in cycle 1.
  - With a divider done L cycles after start, valid_o rises in cycle 2+L.
  - Divide-by-zero: valid_o rises in cycle 1.
- Flush (flush_i=1), priority over all other events:
  - Next state is IDLE, and valid_o falls next cycle.
  - Pointer is unchanged.
  - divAbort_o pulses for 1 cycle if the state was LAUNCH or WAIT.
  - A flush coinciding with divDone_i or canGo_i discards the result.
  - grant_o=0 while flush_i=1.
- Only one op is in flight; grant_o is never asserted outside IDLE.
- Reset mid-operation: immediate return to IDLE, with all outputs at their reset values as listed above.

Test Plan:
1. Single op: req_i=4'b0010, val1=15, val2=3, tag=3, cmd=10, divider L=4, canGo_i=1 -> grant_o=0010 at cycle 0, divStart_o in cycle 1, valid_o in cycle 6 with executeVal_o=5, tag 3, cmd 10, then busy_o drops.
2. Round-robin: req_i=4'b1111 held, each op accepted immediately -> grants in order 0001,0010,0100,1000,0001; with pointer at 2 and req_i=4'b0011 -> grant 0001.
3. Divide-by-zero: val1=7, val2=0 -> divStart_o never asserted; valid_o the next cycle with executeVal_o=all ones.
4. Backpressure: result ready, canGo_i=0 for 5 cycles -> valid_o and data held constant, no new grant despite pending req_i; canGo_i=1 -> IDLE and a grant the following cycle.
5. Flush in WAIT: flush_i pulsed 2 cycles after divStart_o -> divAbort_o pulse next cycle, IDLE, a later divDone_i is ignored, valid_o never rises; flush during DONE with canGo_i=1 -> result dropped.
6. Asynchronous reset asserted mid-WAIT between clock edges -> outputs 0 immediately; after release, req_i=4'b1000 gets grant 1000 (pointer restarted at 0).

Source files
------------

// File: rtl/div_issue_arbiter.sv
// Round-robin issue arbiter that time-shares one iterative divider among NUM_REQ
// divide reservation-station ports, with a divide-by-zero bypass and a held writeback.
module div_issue_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ROBsize    = 32,
    parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*64-1:0]          val1_i,
    input  logic [NUM_REQ*64-1:0]          val2_i,
    input  logic [NUM_REQ*10-1:0]          commands_i,
    input  logic [NUM_REQ*ROBsizeLog-1:0]  tag_i,
    output logic [NUM_REQ-1:0]             grant_o,
    input  logic                           flush_i,
    output logic                           divStart_o,
    output logic [63:0]                    divDividend_o,
    output logic [63:0]                    divDivisor_o,
    output logic                           divAbort_o,
    input  logic                           divDone_i,
    input  logic [63:0]                    divQuotient_i,
    output logic                           valid_o,
    output logic [63:0]                    executeVal_o,
    output logic [9:0]                     executeCommands_o,
    output logic [ROBsizeLog-1:0]          executeTag_o,
    input  logic                           canGo_i,
    output logic                           busy_o
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} divState_e;

    divState_e stateQ, stateD;
    logic [PtrW-1:0] ptrQ, ptrD, winIdx, nextPtr;
    logic [63:0] dividendQ, divisorQ, resultQ;
    logic [9:0] cmdQ;
    logic [ROBsizeLog-1:0] tagQ;
    logic abortQ;
    logic found, doGrant, divisorZero;
    logic [63:0] winDividend, winDivisor;
    logic [9:0] winCmd;
    logic [ROBsizeLog-1:0] winTag;

    // Search upward from the pointer with wrap-around; first set request wins.
    always_comb begin
        logic [PtrW:0] sum;
        winIdx = '0;
        found  = 1'b0;
        sum    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptrQ} + (PtrW + 1)'(i);
            if (sum >= (PtrW + 1)'(NUM_REQ)) begin
                sum = sum - (PtrW + 1)'(NUM_REQ);
            end
            if (!found && req_i[sum[PtrW-1:0]]) begin
                found  = 1'b1;
                winIdx = sum[PtrW-1:0];
            end
        end
    end

    always_comb begin
        winDividend = '0;
        winDivisor  = '0;
        winCmd      = '0;
        winTag      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (winIdx == PtrW'(k)) begin
                winDividend = val1_i[k*64 +: 64];
                winDivisor  = val2_i[k*64 +: 64];
                winCmd      = commands_i[k*10 +: 10];
                winTag      = tag_i[k*ROBsizeLog +: ROBsizeLog];
            end
        end
    end

    // Reset gates the grant so it reads 0 while reset is held.
    assign doGrant     = reset_i && (stateQ == StIdle) && found && !flush_i;
    assign divisorZero = (winDivisor == '0);
    assign nextPtr     = (winIdx == PtrW'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;

    always_comb begin
        grant_o = '0;
        if (doGrant) begin
            grant_o[winIdx] = 1'b1;
        end
    end

    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        if (flush_i) begin
            stateD = StIdle;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (doGrant) begin
                        ptrD   = nextPtr;
                        stateD = divisorZero ? StDone : StLaunch;
                    end
                end
                StLaunch: stateD = StWait;
                StWait:   if (divDone_i) stateD = StDone;
                StDone:   if (canGo_i) stateD = StIdle;
                default:  stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stateQ    <= StIdle;
            ptrQ      <= '0;
            dividendQ <= '0;
            divisorQ  <= '0;
            resultQ   <= '0;
            cmdQ      <= '0;
            tagQ      <= '0;
            abortQ    <= 1'b0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
            abortQ <= flush_i && ((stateQ == StLaunch) || (stateQ == StWait));
            if (doGrant) begin
                dividendQ <= winDividend;
                divisorQ  <= winDivisor;
                cmdQ      <= winCmd;
                tagQ      <= winTag;
                if (divisorZero) begin
                    resultQ <= '1;
                end
            end else if (!flush_i && (stateQ == StWait) && divDone_i) begin
                resultQ <= divQuotient_i;
            end
        end
    end

    assign divStart_o        = (stateQ == StLaunch);
    assign divDividend_o     = dividendQ;
    assign divDivisor_o      = divisorQ;
    assign divAbort_o        = abortQ;
    assign valid_o           = (stateQ == StDone);
    assign executeVal_o      = resultQ;
    assign executeCommands_o = cmdQ;
    assign executeTag_o      = tagQ;
    assign busy_o            = (stateQ != StIdle);

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Directed bench for div_issue_arbiter: a table of single ops with a small divider model,
// then hand-written backpressure, flush and asynchronous-reset sequences.
module tb_div_issue_arbiter;

    localparam int TW = 6;

    logic clk, reset;
    logic [3:0] req, grant;
    logic [3:0][63:0] val1Bus, val2Bus;
    logic [3:0][9:0] cmdBus;
    logic [3:0][TW-1:0] tagBus;
    logic flush, divStart, divAbort, divDone, valid, canGo, busy;
    logic [63:0] divDividend, divDivisor, divQuotient, executeVal;
    logic [9:0] executeCommands;
    logic [TW-1:0] executeTag;

    int nApplied = 0;
    int nMiss = 0;

    div_issue_arbiter #(.NUM_REQ(4), .ROBsize(32)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .val1_i(val1Bus), .val2_i(val2Bus),
        .commands_i(cmdBus), .tag_i(tagBus), .grant_o(grant), .flush_i(flush),
        .divStart_o(divStart), .divDividend_o(divDividend), .divDivisor_o(divDivisor),
        .divAbort_o(divAbort), .divDone_i(divDone), .divQuotient_i(divQuotient),
        .valid_o(valid), .executeVal_o(executeVal), .executeCommands_o(executeCommands),
        .executeTag_o(executeTag), .canGo_i(canGo), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    rq;
        logic [3:0]    gnt;
        logic [63:0]   v1;
        logic [63:0]   v2;
        logic [9:0]    cmd;
        logic [TW-1:0] tag;
        int            lat;
        logic [63:0]   res;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nApplied++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The slot named by win gets the op under test; every other slot carries distinct decoys.
    task automatic driveSlots(input logic [3:0] win, input logic [63:0] v1, input logic [63:0] v2,
                              input logic [9:0] cmd, input logic [TW-1:0] tag);
        for (int k = 0; k < 4; k++) begin
            if (win[k]) begin
                val1Bus[k] = v1;
                val2Bus[k] = v2;
                cmdBus[k]  = cmd;
                tagBus[k]  = tag;
            end else begin
                val1Bus[k] = 64'(100 + k);
                val2Bus[k] = 64'd1;
                cmdBus[k]  = 10'(500 + k);
                tagBus[k]  = TW'(20 + k);
            end
        end
    endtask

    task automatic runOp(input vec_t v);
        logic [63:0] q;
        step();
        req = v.rq;
        driveSlots(v.gnt, v.v1, v.v2, v.cmd, v.tag);
        canGo = 1'b1;
        divDone = 1'b0;
        @(negedge clk);
        chk("grant", 64'(grant), 64'(v.gnt));
        chk("busy before grant", 64'(busy), 64'd0);
        step();
        req = 4'b0000;
        @(negedge clk);
        if (v.v2 == 64'd0) begin
            chk("div0 no start", 64'(divStart), 64'd0);
            chk("div0 valid", 64'(valid), 64'd1);
            chk("div0 result", executeVal, v.res);
            chk("div0 tag", 64'(executeTag), 64'(v.tag));
            chk("div0 cmd", 64'(executeCommands), 64'(v.cmd));
        end else begin
            chk("start", 64'(divStart), 64'd1);
            chk("dividend", divDividend, v.v1);
            chk("divisor", divDivisor, v.v2);
            q = (divDivisor != 64'd0) ? divDividend / divDivisor : 64'hBAD0;
            for (int c = 2; c <= 1 + v.lat; c++) begin
                step();
                divDone = (c == 1 + v.lat);
                divQuotient = q;
                @(negedge clk);
                chk("valid early", 64'(valid), 64'd0);
                chk("start one cycle", 64'(divStart), 64'd0);
            end
            step();
            divDone = 1'b0;
            divQuotient = 64'hBAD1;
            @(negedge clk);
            chk("valid", 64'(valid), 64'd1);
            chk("result", executeVal, v.res);
            chk("tag", 64'(executeTag), 64'(v.tag));
            chk("cmd", 64'(executeCommands), 64'(v.cmd));
        end
        step();
        @(negedge clk);
        chk("valid drop", 64'(valid), 64'd0);
        chk("busy drop", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{rq: 4'b0010, gnt: 4'b0010, v1: 64'd15, v2: 64'd3, cmd: 10'd10, tag: 6'd3,
                    lat: 4, res: 64'd5};
        vecs[1] = '{rq: 4'b1111, gnt: 4'b0100, v1: 64'd100, v2: 64'd7, cmd: 10'd33, tag: 6'd5,
                    lat: 2, res: 64'd14};
        vecs[2] = '{rq: 4'b1111, gnt: 4'b1000, v1: 64'd7, v2: 64'd0, cmd: 10'd1, tag: 6'd9,
                    lat: 1, res: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{rq: 4'b1111, gnt: 4'b0001, v1: 64'hFFFF_FFFF_FFFF_FFFF, v2: 64'd16,
                    cmd: 10'd1023, tag: 6'd31, lat: 1, res: 64'h0FFF_FFFF_FFFF_FFFF};
        vecs[4] = '{rq: 4'b1111, gnt: 4'b0010, v1: 64'd1000, v2: 64'd10, cmd: 10'd512, tag: 6'd0,
                    lat: 3, res: 64'd100};
        vecs[5] = '{rq: 4'b0011, gnt: 4'b0001, v1: 64'd9, v2: 64'd9, cmd: 10'd2, tag: 6'd7,
                    lat: 1, res: 64'd1};
        vecs[6] = '{rq: 4'b1001, gnt: 4'b1000, v1: 64'd50, v2: 64'd0, cmd: 10'd44, tag: 6'd12,
                    lat: 1, res: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{rq: 4'b0100, gnt: 4'b0100, v1: 64'd3, v2: 64'd5, cmd: 10'd6, tag: 6'd1,
                    lat: 2, res: 64'd0};

        reset = 1'b0;
        req = 4'b1111;
        flush = 1'b0;
        canGo = 1'b0;
        divDone = 1'b0;
        divQuotient = '0;
        driveSlots(4'b0001, 64'd1, 64'd1, 10'd1, 6'd1);
        #3;
        chk("reset grant", 64'(grant), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset start", 64'(divStart), 64'd0);
        chk("reset abort", 64'(divAbort), 64'd0);
        chk("reset result", executeVal, 64'd0);
        step();
        reset = 1'b1;
        req = 4'b0000;

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i]);
        end

        // Backpressure: result held, pending requests ignored until one bubble after canGo.
        step();
        req = 4'b0001;
        driveSlots(4'b0001, 64'd20, 64'd4, 10'd77, 6'd4);
        canGo = 1'b0;
        @(negedge clk);
        chk("bp grant", 64'(grant), 64'b0001);
        step();
        req = 4'b0110;
        @(negedge clk);
        chk("bp start", 64'(divStart), 64'd1);
        chk("bp no grant busy", 64'(grant), 64'd0);
        step();
        divDone = 1'b1;
        divQuotient = 64'd5;
        @(negedge clk);
        chk("bp valid early", 64'(valid), 64'd0);
        step();
        divDone = 1'b0;
        divQuotient = 64'hBAD2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp valid held", 64'(valid), 64'd1);
            chk("bp result held", executeVal, 64'd5);
            chk("bp no grant", 64'(grant), 64'd0);
            step();
        end
        canGo = 1'b1;
        @(negedge clk);
        chk("bp accept valid", 64'(valid), 64'd1);
        chk("bp bubble", 64'(grant), 64'd0);
        step();
        @(negedge clk);
        chk("bp idle", 64'(busy), 64'd0);
        chk("bp next grant", 64'(grant), 64'b0010);

        // Flush in WAIT: abort pulse, late done ignored.
        step();
        req = 4'b0000;
        canGo = 1'b0;
        @(negedge clk);
        chk("fl start", 64'(divStart), 64'd1);
        chk("fl dividend", divDividend, 64'd101);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("fl abort late", 64'(divAbort), 64'd0);
        step();
        flush = 1'b0;
        divDone = 1'b1;
        divQuotient = 64'hBAD3;
        @(negedge clk);
        chk("fl abort", 64'(divAbort), 64'd1);
        chk("fl idle", 64'(busy), 64'd0);
        step();
        divDone = 1'b0;
        @(negedge clk);
        chk("fl abort pulse", 64'(divAbort), 64'd0);
        chk("fl no valid", 64'(valid), 64'd0);

        // No grant while flushing; pointer left at 2 by the flushed op.
        step();
        req = 4'b0100;
        driveSlots(4'b0100, 64'd42, 64'd6, 10'd99, 6'd17);
        flush = 1'b1;
        @(negedge clk);
        chk("fl grant blocked", 64'(grant), 64'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl ptr kept", 64'(grant), 64'b0100);
        step();
        req = 4'b0000;
        step();
        divDone = 1'b1;
        divQuotient = 64'd7;
        step();
        divDone = 1'b0;
        @(negedge clk);
        chk("fd valid", 64'(valid), 64'd1);
        chk("fd result", executeVal, 64'd7);
        chk("fd tag", 64'(executeTag), 64'd17);
        step();
        canGo = 1'b1;
        flush = 1'b1;
        step();
        canGo = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("fd dropped", 64'(valid), 64'd0);
        chk("fd no abort", 64'(divAbort), 64'd0);
        step();
        @(negedge clk);
        chk("fd stays dropped", 64'(valid), 64'd0);

        // Asynchronous reset mid-WAIT, pointer previously at 3.
        step();
        req = 4'b0100;
        driveSlots(4'b0100, 64'd10, 64'd2, 10'd5, 6'd11);
        @(negedge clk);
        chk("rs grant", 64'(grant), 64'b0100);
        step();
        req = 4'b0000;
        step();
        @(negedge clk);
        chk("rs in wait", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs busy", 64'(busy), 64'd0);
        chk("rs valid", 64'(valid), 64'd0);
        chk("rs result", executeVal, 64'd0);
        chk("rs dividend", divDividend, 64'd0);
        chk("rs tag", 64'(executeTag), 64'd0);
        chk("rs cmd", 64'(executeCommands), 64'd0);
        step();
        reset = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        chk("rs ptr restart", 64'(grant), 64'b0001);
        step();
        req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
